// File: rtl/neuron_acc.sv
// neuron_acc: binary-neuron accumulation stage for the +/-1 ALU datapath.
// Preloads a signed bias, then adds 1 for every matching (in_x, in_w) pair
// and subtracts 1 for every mismatch. The final sum and its sign are handed
// downstream over a valid/ready handshake.
// Optional build macro NEURON_ACC_SAT_EN: out-of-range steps saturate to the
// signed limits. Without it, steps wrap modulo 2^ACC_WIDTH like a plain ALU.
// ovf flags an out-of-range step in both builds.
module neuron_acc #(
  parameter int ACC_WIDTH = 12,
  parameter int N_INPUTS  = 784,
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ACC_WIDTH-1:0] bias,
  input  logic                 in_valid,
  input  logic                 in_x,
  input  logic                 in_w,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 act_out,
  output logic                 ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(N_INPUTS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [ACC_WIDTH:0]   ONE_EXT  = (ACC_WIDTH + 1)'(1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH - 1){1'b0}}};

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]   acc_out_q, acc_out_d;
  logic                   act_out_q, act_out_d;

  logic                   op;
  logic [ACC_WIDTH:0]     acc_ext;
  logic [ACC_WIDTH:0]     step_sum;
  logic                   step_ovf;
  logic [ACC_WIDTH-1:0]   step_val;

  // One +/-1 step computed one bit wider so range excursions are visible,
  // then either saturated or wrapped back to ACC_WIDTH bits.
  always_comb begin
    op       = in_x ^ in_w;
    acc_ext  = {acc_q[ACC_WIDTH-1], acc_q};
    step_sum = op ? (acc_ext - ONE_EXT) : (acc_ext + ONE_EXT);
    step_ovf = step_sum[ACC_WIDTH] ^ step_sum[ACC_WIDTH-1];
`ifdef NEURON_ACC_SAT_EN
    if (step_ovf) begin
      step_val = op ? ACC_MIN : ACC_MAX;
    end else begin
      step_val = step_sum[ACC_WIDTH-1:0];
    end
`else
    step_val = step_sum[ACC_WIDTH-1:0];
`endif
  end

  // Next-state logic for the IDLE/ACCUM/DONE sequence and the datapath,
  // plus next values of the registered outputs derived from the next state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = bias;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = step_val;
          cnt_d = cnt_q + CNT_ONE;
          ovf_d = ovf_q | step_ovf;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_ACCUM);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_DONE);
    acc_out_d   = (state_d == S_DONE) ? acc_d : '0;
    act_out_d   = (state_d == S_DONE) ? ~acc_d[ACC_WIDTH-1] : 1'b0;
  end

  // Single state register for the FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      act_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      acc_out_q   <= acc_out_d;
      act_out_q   <= act_out_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign act_out   = act_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_neuron_acc.sv
// tb_neuron_acc: scoreboard bench for neuron_acc with N_INPUTS = 8.
// Expected results are hand-computed and queued when a neuron is issued;
// a monitor compares them whenever the DUT presents out_valid.
// Overflow expectations follow NEURON_ACC_SAT_EN when it is defined.
module tb_neuron_acc;

  localparam int ACC_WIDTH = 12;
  localparam int N_INPUTS  = 8;
  localparam int CNT_WIDTH = 4;

  typedef struct {
    int acc;
    bit act;
    bit ovf;
  } exp_t;

  logic                        clk;
  logic                        rst;
  logic                        start;
  logic signed [ACC_WIDTH-1:0] bias;
  logic                        in_valid;
  logic                        in_x;
  logic                        in_w;
  logic                        in_ready;
  logic                        busy;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] acc_out;
  logic                        act_out;
  logic                        ovf;

  exp_t exp_q[$];
  exp_t mon_exp;
  int   checks;
  int   errors;

  neuron_acc #(
    .ACC_WIDTH(ACC_WIDTH),
    .N_INPUTS (N_INPUTS),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .in_x     (in_x),
    .in_w     (in_w),
    .in_ready (in_ready),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .act_out  (act_out),
    .ovf      (ovf)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not reach its end (required: finish)");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: compares every presented result against the queue head,
  // pops only when the handshake completes.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_valid", 1, 0);
        end else begin
          mon_exp = exp_q[0];
          checkOutput("acc_out", acc_out, mon_exp.acc);
          checkOutput("act_out", act_out, mon_exp.act);
          checkOutput("ovf", ovf, mon_exp.ovf);
          if (out_ready === 1'b1) begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic pushExpected(input int acc, input bit act, input bit ovf_e);
    exp_t e;
    e.acc = acc;
    e.act = act;
    e.ovf = ovf_e;
    exp_q.push_back(e);
  endtask

  task automatic startNeuron(input logic signed [ACC_WIDTH-1:0] b);
    start = 1'b1;
    bias  = b;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("in_ready_after_start", in_ready, 1);
    checkOutput("busy_after_start", busy, 1);
  endtask

  // Feeds N_INPUTS pairs; mask bit i set means pair i matches.
  task automatic sendPairs(input logic [N_INPUTS-1:0] mask, input bit stall);
    for (int i = 0; i < N_INPUTS; i++) begin
      if (stall && i > 0) begin
        in_valid = 1'b0;
        in_x     = 1'($urandom_range(0, 1));
        in_w     = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_x     = 1'($urandom_range(0, 1));
      in_w     = mask[i] ? in_x : ~in_x;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    checkOutput("out_valid_latency", out_valid, 1);
    checkOutput("in_ready_in_done", in_ready, 0);
  endtask

  task automatic waitDone();
    int budget;
    budget = 40;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (exp_q.size() != 0) begin
      checkOutput("done_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
    end
    checkOutput("out_valid_after_handshake", out_valid, 0);
    checkOutput("busy_after_handshake", busy, 0);
  endtask

  task automatic applyStimulus(input logic signed [ACC_WIDTH-1:0] b,
                               input logic [N_INPUTS-1:0] mask, input bit stall,
                               input int exp_acc, input bit exp_act, input bit exp_ovf);
    pushExpected(exp_acc, exp_act, exp_ovf);
    startNeuron(b);
    sendPairs(mask, stall);
    waitDone();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    in_x      = 1'b0;
    in_w      = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_acc_out", acc_out, 0);
    checkOutput("reset_act_out", act_out, 0);
    checkOutput("reset_ovf", ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic mix");
    applyStimulus(12'sd0, 8'b0001_1111, 1'b0, 2, 1'b1, 1'b0);

    $display("[TB] negative result with stalls");
    applyStimulus(-12'sd3, 8'b0000_0000, 1'b1, -11, 1'b0, 1'b0);

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    pushExpected(9, 1'b1, 1'b0);
    startNeuron(12'sd1);
    sendPairs(8'hFF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      start = k[0];
      @(posedge clk); #1;
      start = 1'b0;
    end
    checkOutput("held_out_valid", out_valid, 1);
    checkOutput("held_busy", busy, 1);
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("idle_out_valid", out_valid, 0);
    checkOutput("start_with_ready_ignored", in_ready, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("backpressure_pending", exp_q.size(), 0);
    @(posedge clk); #1;
    checkOutput("still_idle_in_ready", in_ready, 0);

    $display("[TB] overflow");
`ifdef NEURON_ACC_SAT_EN
    applyStimulus(12'sd2046, 8'hFF, 1'b0, 2047, 1'b1, 1'b1);
    applyStimulus(-12'sd2047, 8'h00, 1'b0, -2048, 1'b0, 1'b1);
`else
    applyStimulus(12'sd2046, 8'hFF, 1'b0, -2042, 1'b0, 1'b1);
    applyStimulus(-12'sd2047, 8'h00, 1'b0, 2041, 1'b1, 1'b1);
`endif

    $display("[TB] reset mid-operation");
    startNeuron(12'sd7);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_x     = 1'b1;
      in_w     = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_acc_out", acc_out, 0);
    checkOutput("midrst_act_out", act_out, 0);
    checkOutput("midrst_ovf", ovf, 0);
    applyStimulus(12'sd5, 8'hFF, 1'b0, 13, 1'b1, 1'b0);

    $display("[TB] zero boundary");
    applyStimulus(12'sd4, 8'h0F, 1'b0, 4, 1'b1, 1'b0);
    applyStimulus(-12'sd4, 8'hF0, 1'b0, -4, 1'b0, 1'b0);
    applyStimulus(12'sd0, 8'b1010_0101, 1'b0, 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
